// File: rtl/serial_adder_n_pkg.sv
// Shared definitions for the chunked serial add/subtract unit:
// FSM state encodings and a width helper for the chunk counter.
package serial_adder_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_n_full_adder_1bit.sv
// One-bit full adder cell; the top chains several of these into a ripple slice.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle add/subtract: a BITS_PER_CYCLE-wide ripple slice walks the operands
// LSB chunk first, carrying between chunks through a register.
//
// Handshake: ready=1 means a start seen at the next rising edge is accepted and
// a, b, sub are captured on that edge; start while busy is dropped. done is a
// one-cycle pulse marking the cycle in which sum/cout/ovf first hold the new result.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           state
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = clog2_min1(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [WIDTH-1:0]          a_sh;
  logic [WIDTH-1:0]          b_sh;
  logic [WIDTH-1:0]          sum_sh;
  logic                      carry;
  logic [CW-1:0]             cnt;
  logic [BITS_PER_CYCLE:0]   c;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [WIDTH-1:0]          sum_next;

  assign c[0] = carry;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
    full_adder_1bit u_fa (
      .a    (a_sh[i]),
      .b    (b_sh[i]),
      .cin  (c[i]),
      .s    (chunk[i]),
      .cout (c[i+1])
    );
  end

  // New chunk enters at the top; after N chunks the LSB chunk has reached bit 0.
  assign sum_next = WIDTH'({chunk, sum_sh} >> BITS_PER_CYCLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            sum_sh <= '0;
            state  <= ST_RUN;
            busy   <= 1'b1;
            ready  <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> BITS_PER_CYCLE;
          b_sh   <= b_sh >> BITS_PER_CYCLE;
          sum_sh <= sum_next;
          carry  <= c[BITS_PER_CYCLE];
          if (cnt == LAST) begin
            // The top cell of the last chunk is bit WIDTH-1, so its carry-in feeds ovf.
            sum   <= sum_next;
            cout  <= c[BITS_PER_CYCLE];
            ovf   <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
            done  <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: an 8-bit bit-serial instance and a
// 16-bit nibble-serial instance sharing one clock and reset.
module tb_serial_adder_n;
  import serial_adder_n_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start8, sub8, ready8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  state_t      st8;

  logic        start16, sub16, ready16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  state_t      st16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];

  serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8), .state(st8)
  );

  serial_adder_n #(.WIDTH(16), .BITS_PER_CYCLE(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .sub(sub16),
    .ready(ready16), .busy(busy16), .done(done16), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .state(st16)
  );

  // ---------------- clock/reset helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done8 && lat < 40);
    check("done8_seen", 32'(done8), 1);
  endtask

  task automatic start16_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    a16 = a; b16 = b; sub16 = s; start16 = 1'b1;
    tick();
    start16 = 1'b0;
  endtask

  task automatic wait_done16(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done16 && lat < 40);
    check("done16_seen", 32'(done16), 1);
  endtask

  // Reference: {ovf, cout, sum} for a 16-bit add/sub in two's complement.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] bb;
    logic [16:0] full;
    logic        v;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, s};
    v    = (a[15] == bb[15]) && (full[15] != a[15]);
    return {v, full[16], full[15:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gap, ndone, first;
    logic [15:0] ra, rb;
    logic        rs;
    logic [17:0] expv;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_ready", 32'(ready8), 1);
    check("rst_busy",  32'(busy8),  0);
    check("rst_done",  32'(done8),  0);
    check("rst_sum",   32'(sum8),   0);
    check("rst_cout",  32'(cout8),  0);
    check("rst_ovf",   32'(ovf8),   0);
    check("rst_state", 32'(st8),    32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // T1: 100 + 55
    start8_op(8'd100, 8'd55, 1'b0);
    check("t1_busy",  32'(busy8),  1);
    check("t1_ready", 32'(ready8), 0);
    check("t1_state", 32'(st8),    32'(ST_RUN));
    check("t1_sum_mid", 32'(sum8), 0);
    wait_done8(lat);
    check("t1_lat",  32'(lat),   8);
    check("t1_sum",  32'(sum8),  'h9B);
    check("t1_cout", 32'(cout8), 0);
    check("t1_ovf",  32'(ovf8),  1);
    check("t1_ready_done", 32'(ready8), 1);
    tick();
    check("t1_done_pulse", 32'(done8), 0);
    check("t1_idle", 32'(st8), 32'(ST_IDLE));
    check("t1_sum_held", 32'(sum8), 'h9B);

    // T2: FF + 01, then 5 - 7
    start8_op(8'hFF, 8'h01, 1'b0);
    wait_done8(lat);
    check("t2a_sum",  32'(sum8),  'h00);
    check("t2a_cout", 32'(cout8), 1);
    check("t2a_ovf",  32'(ovf8),  0);
    tick();
    start8_op(8'd5, 8'd7, 1'b1);
    wait_done8(lat);
    check("t2b_sum",  32'(sum8),  'hFE);
    check("t2b_cout", 32'(cout8), 0);
    check("t2b_ovf",  32'(ovf8),  0);
    tick();

    // T3: 80 - 01, then start held in the DONE cycle
    start8_op(8'h80, 8'h01, 1'b1);
    wait_done8(lat);
    check("t3_sum",  32'(sum8),  'h7F);
    check("t3_cout", 32'(cout8), 1);
    check("t3_ovf",  32'(ovf8),  1);
    start8_op(8'd3, 8'd4, 1'b0);
    check("t3_b2b_busy", 32'(busy8), 1);
    wait_done8(lat);
    gap = lat + 1;
    check("t3_b2b_gap", 32'(gap), 9);
    check("t3_b2b_sum", 32'(sum8), 'h07);
    tick();

    // T4: start pulsed mid-run with different operands is ignored
    start8_op(8'h10, 8'h20, 1'b0);
    tick();
    tick();
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t4_busy", 32'(busy8), 1);
    ndone = 0;
    first = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    check("t4_ndone", 32'(ndone), 1);
    check("t4_when",  32'(first), 4);
    check("t4_sum",   32'(sum8),  'h30);
    check("t4_cout",  32'(cout8), 0);
    check("t4_ovf",   32'(ovf8),  0);

    // T5: reset 4 cycles into RUN aborts with no done
    start8_op(8'd1, 8'd2, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_ready", 32'(ready8), 1);
    check("t5_busy",  32'(busy8),  0);
    check("t5_sum",   32'(sum8),   0);
    check("t5_done",  32'(done8),  0);
    check("t5_state", 32'(st8),    32'(ST_IDLE));
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    check("t5_no_done", 32'(ndone), 0);

    // Reset and start together: reset wins
    rst = 1'b1; a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    check("rst_start_state", 32'(st8),   32'(ST_IDLE));
    check("rst_start_busy",  32'(busy8), 0);
    tick();
    check("rst_start_stay",  32'(st8),   32'(ST_IDLE));

    // T6: 16-bit, 4 bits per cycle
    start16_op(16'h7FFF, 16'h0001, 1'b0);
    check("t6_busy", 32'(busy16), 1);
    wait_done16(lat);
    check("t6_lat",  32'(lat),    4);
    check("t6_sum",  32'(sum16),  'h8000);
    check("t6_cout", 32'(cout16), 0);
    check("t6_ovf",  32'(ovf16),  1);
    tick();
    start16_op(16'h1234, 16'h1234, 1'b1);
    wait_done16(lat);
    check("t6_eq_sum",  32'(sum16),  'h0000);
    check("t6_eq_cout", 32'(cout16), 1);
    check("t6_eq_ovf",  32'(ovf16),  0);

    // Random sweep against the reference, back-to-back through the DONE cycle
    for (int k = 0; k < 24; k++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model16(ra, rb, rs));
      start16_op(ra, rb, rs);
      wait_done16(lat);
      expv = exp_q.pop_front();
      check("rnd16_result", 32'({ovf16, cout16, sum16}), 32'(expv));
      check("rnd16_lat", 32'(lat), 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
